// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with a one-byte holding register and frame/overrun flags.
// Optional even-parity stage and parity_err output are enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       rx,
   input  logic       rd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       busy
);

   localparam int unsigned Shift = 8 - DBIT;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e     state_q, state_d;
   logic [4:0] tick_q, tick_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       rx_meta_q, rx_sync_q;
   logic [1:0] settle_q;
   logic       armed_q;
   logic       complete;
   logic [7:0] data_word;
   logic [7:0] rx_data_q;
   logic       rx_valid_q, frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
   logic       par_q, par_d;
   logic       parity_err_q;
`endif

   // Start detection stays disarmed until the settled line has been seen high,
   // so a line already low at reset release never starts a frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         settle_q  <= 2'd0;
         armed_q   <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
         armed_q   <= armed_q | ((settle_q == 2'd2) & rx_sync_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      complete = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (armed_q && !rx_sync_q) begin
               state_d = StStart;
               tick_d  = '0;
            end
         end
         StStart: begin
            if (s_tick) begin
               if (tick_q == 5'd7) begin
                  tick_d = '0;
                  if (!rx_sync_q) begin
                     state_d = StData;
                     bit_d   = '0;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
         StData: begin
            if (s_tick) begin
               if (tick_q == 5'd15) begin
                  tick_d  = '0;
                  shift_d = {rx_sync_q, shift_q[7:1]};
                  if (bit_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (s_tick) begin
               if (tick_q == 5'd15) begin
                  tick_d  = '0;
                  par_d   = rx_sync_q;
                  state_d = StStop;
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
`endif
         StStop: begin
            if (s_tick) begin
               if (tick_q == 5'(SB_TICK - 1)) begin
                  complete = 1'b1;
                  tick_d   = '0;
                  state_d  = StIdle;
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // LSB-first shifting leaves the frame in the top DBIT bits.
   assign data_word = shift_q >> Shift;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else if (complete && (!rx_valid_q || rd)) begin
         rx_data_q    <= data_word;
         rx_valid_q   <= 1'b1;
         frame_err_q  <= ~rx_sync_q;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= ^{data_word, par_q};
`endif
      end else if (complete) begin
         overrun_q <= 1'b1;
      end else if (rd && rx_valid_q) begin
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = parity_err_q;
`endif
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus hand-written timing, false-start,
// rd-on-completion and mid-frame reset sequences. s_tick pulses every 4 clocks.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
   localparam int FinalTicks = 8 + 16 * 8 + 16 + 16;
`else
   localparam int FinalTicks = 8 + 16 * 8 + 16;
`endif

   logic       clk;
   logic       reset;
   logic       s_tick;
   logic       rx;
   logic       rd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun_err;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   uart_rx dut (
      .clk        (clk),
      .reset      (reset),
      .s_tick     (s_tick),
      .rx         (rx),
      .rd         (rd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_err  (frame_err),
      .overrun_err(overrun_err),
`ifdef UART_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int   phase    = 0;
   int   tick_cnt = 0;
   logic counting = 1'b0;
   logic rd_final = 1'b0;
   logic fin_seen = 1'b0;
   logic fin_valid, fin_busy, pb_valid, pb_busy;

   typedef struct {
      logic       pulse;
      logic [7:0] data;
      logic       stop;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_ferr;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[6];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // One clock: set s_tick for the coming edge, sample #1 after it. Counts ticks from
   // the start-detect so the frame-completion edge is known (and rd can hit it exactly).
   task automatic step();
      logic pv, pbz, hit;
      phase  = (phase + 1) % 4;
      s_tick = (phase == 0);
      if (rd_final) rd = counting && s_tick && (tick_cnt == FinalTicks - 1);
      pv  = rx_valid;
      pbz = busy;
      @(posedge clk);
      hit = counting && s_tick && (tick_cnt == FinalTicks - 1);
      if (counting && s_tick) tick_cnt++;
      #1;
      if (hit) begin
         fin_seen  = 1'b1;
         fin_valid = rx_valid;
         fin_busy  = busy;
         pb_valid  = pv;
         pb_busy   = pbz;
      end
      if (!busy) counting = 1'b0;
      else if (!counting) begin
         counting = 1'b1;
         tick_cnt = 0;
      end
   endtask

   // Stop level is held for 40 clocks (past the mid-bit sample), then the line idles.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
      rx = 1'b0;
      repeat (64) step();
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (64) step();
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      repeat (64) step();
`else
      if (par === 1'bx) rx = 1'b1;
`endif
      rx = stop;
      repeat (40) step();
      rx = 1'b1;
      repeat (24) step();
      repeat (64) step();
   endtask

   task automatic pulse_rd();
      rd = 1'b1;
      step();
      rd = 1'b0;
      step();
   endtask

   initial begin
      reset  = 1'b0;
      rx     = 1'b1;
      rd     = 1'b0;
      s_tick = 1'b0;
      repeat (3) step();
      chk8("reset_data", rx_data, 8'h00);
      chk1("reset_valid", rx_valid, 1'b0);
      chk1("reset_ferr", frame_err, 1'b0);
      chk1("reset_ovr", overrun_err, 1'b0);
      chk1("reset_busy", busy, 1'b0);
`ifdef UART_RX_PARITY_EN
      chk1("reset_perr", parity_err, 1'b0);
`endif
      reset = 1'b1;
      repeat (8) step();

      // 0xA5, valid stop: byte appears exactly on the final STOP tick edge.
      fin_seen = 1'b0;
      send_frame(8'hA5, ^8'hA5, 1'b1);
      chk1("a5_final_seen", fin_seen, 1'b1);
      chk1("a5_valid_before", pb_valid, 1'b0);
      chk1("a5_busy_before", pb_busy, 1'b1);
      chk1("a5_valid_at", fin_valid, 1'b1);
      chk1("a5_busy_at", fin_busy, 1'b0);
      chk8("a5_data", rx_data, 8'hA5);
      chk1("a5_ferr", frame_err, 1'b0);

      vecs[0] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 8'h22, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
      for (int v = 0; v < 6; v++) begin
         if (vecs[v].pulse) begin
            pulse_rd();
            chk1($sformatf("v%0d_rd_valid", v), rx_valid, 1'b0);
            chk1($sformatf("v%0d_rd_ovr", v), overrun_err, 1'b0);
         end
         send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop);
         chk8($sformatf("v%0d_data", v), rx_data, vecs[v].exp_data);
         chk1($sformatf("v%0d_valid", v), rx_valid, vecs[v].exp_valid);
         chk1($sformatf("v%0d_ferr", v), frame_err, vecs[v].exp_ferr);
         chk1($sformatf("v%0d_ovr", v), overrun_err, vecs[v].exp_ovr);
      end

      // False start: line low for 5 ticks only.
      pulse_rd();
      rx = 1'b0;
      repeat (20) step();
      chk1("fs_busy_mid", busy, 1'b1);
      rx = 1'b1;
      repeat (60) step();
      chk1("fs_busy_end", busy, 1'b0);
      chk1("fs_valid", rx_valid, 1'b0);

      // rd lands on the completion edge of the second frame.
      send_frame(8'h11, ^8'h11, 1'b1);
      chk8("rdc_first", rx_data, 8'h11);
      rd_final = 1'b1;
      send_frame(8'h22, ^8'h22, 1'b1);
      rd_final = 1'b0;
      rd       = 1'b0;
      chk8("rdc_data", rx_data, 8'h22);
      chk1("rdc_valid", rx_valid, 1'b1);
      chk1("rdc_ovr", overrun_err, 1'b0);

      // Reset during data bit 3, released with the line held low.
      pulse_rd();
      rx = 1'b0;
      repeat (64) step();
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         repeat (64) step();
      end
      rx = 1'b0;
      repeat (30) step();
      reset = 1'b0;
      step();
      step();
      chk1("mrst_busy", busy, 1'b0);
      chk8("mrst_data", rx_data, 8'h00);
      chk1("mrst_valid", rx_valid, 1'b0);
      reset = 1'b1;
      repeat (200) step();
      chk1("mrst_low_busy", busy, 1'b0);
      chk1("mrst_low_valid", rx_valid, 1'b0);
      rx = 1'b1;
      repeat (64) step();
      send_frame(8'h5A, ^8'h5A, 1'b1);
      chk8("mrst_new_data", rx_data, 8'h5A);
      chk1("mrst_new_valid", rx_valid, 1'b1);

`ifdef UART_RX_PARITY_EN
      pulse_rd();
      send_frame(8'h07, 1'b0, 1'b1);
      chk8("par_bad_data", rx_data, 8'h07);
      chk1("par_bad_perr", parity_err, 1'b1);
      pulse_rd();
      send_frame(8'h07, 1'b1, 1'b1);
      chk1("par_ok_perr", parity_err, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DBIT, default 8, data bits per frame (5..8).
REQ-002 SHALL provide parameter SB_TICK, default 16, s_tick count for one stop bit (16 = 1 stop bit, 32 = 2).
REQ-003 SHALL provide port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port s_tick  input  1  one-clk enable pulse at 16x baud rate, from the baud generator.
REQ-006 SHALL provide port rx  input  1  asynchronous serial line; idle high.
REQ-007 SHALL provide port rd  input  1  consumer acknowledge; pops the held byte.
REQ-008 SHALL provide port rx_data  output  8  received byte, LSB-aligned; bits above DBIT-1 are 0.
REQ-009 SHALL provide port rx_valid  output  1  rx_data holds an unread byte.
REQ-010 SHALL provide port frame_err  output  1  last completed frame had stop bit sampled low.
REQ-011 SHALL provide port overrun_err  output  1  a frame completed while rx_valid=1; sticky.
REQ-012 SHALL provide port busy  output  1  FSM not in IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); the FSM uses only the synchronized value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, plus PARITY when the macro in REQ-027 is defined.
REQ-015 In IDLE, a synchronized rx=0 SHALL move to START with tick counter cleared, independent of s_tick.
REQ-016 In START, on the 8th s_tick (counter=7), the FSM SHALL go to DATA if rx=0; otherwise it SHALL return to IDLE (false start) with no output change.
REQ-017 In DATA, on every 16th s_tick (counter=15), the block SHALL shift rx into the MSB of the shift register (LSB-first line order); after DBIT samples it SHALL go to STOP.
REQ-018 In STOP, on s_tick with counter=SB_TICK-1, the block SHALL sample rx, complete the frame, and return to IDLE in the same cycle.
REQ-019 On frame completion with rx_valid=0, or with rd=1 in the same cycle, the block SHALL load rx_data, set rx_valid=1, and set frame_err=(stop sample==0); visible the next clk.
REQ-020 On frame completion with rx_valid=1 and rd=0, the block SHALL drop the new frame, keep rx_data and frame_err, and set overrun_err=1.
REQ-021 rd=1 with rx_valid=1 SHALL clear rx_valid and overrun_err on the next clk; rd with rx_valid=0 SHALL have no effect.
REQ-022 Counters SHALL advance only on s_tick=1; the tick counter SHALL be 5 bits and the bit counter 3 bits, with no wrap beyond the terminal values above.
REQ-023 s_tick while in IDLE SHALL have no effect.

Reset
REQ-024 reset=0 at a rising clk SHALL force IDLE, clear counters and shift register, and set rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; after release, a new start bit SHALL be required, even if rx is already low.
REQ-026 After reset release, the synchronizer SHALL hold idle-high for 2 clks before any start detect.

Configuration
REQ-027 When UART_RX_PARITY_EN is defined, the block SHALL sample one even-parity bit in PARITY (counter=15) between DATA and STOP, and SHALL add output parity_err (1 bit), loaded/held/cleared exactly as frame_err (REQ-019..021, REQ-024).
REQ-028 When UART_RX_PARITY_EN is undefined, the PARITY state and the parity_err port SHALL not exist, and DATA SHALL go directly to STOP.

Verification
REQ-029 s_tick every 4 clk, send 0xA5 with valid stop -> rx_valid=1, rx_data=0xA5, frame_err=0, 1 clk after the final STOP tick.
REQ-030 rx low for 5 s_ticks then high -> FSM returns to IDLE, rx_valid stays 0, busy drops.
REQ-031 Send 0x3C with stop bit held 0 -> rx_data=0x3C, frame_err=1.
REQ-032 Send 0x11 then 0x22 with no rd -> rx_data=0x11, overrun_err=1; pulse rd -> rx_valid=0, overrun_err=0.
REQ-033 rd asserted in the same cycle the second frame (0x22) completes -> rx_data=0x22, rx_valid=1, overrun_err=0.
REQ-034 reset=0 during DATA bit 3, then release with rx=0 -> no byte delivered until a fresh high-to-low start; with UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err=1.
